compare_tracker: RTL

Parametrised, registered successor to the 4-bit pair comparator/max selector. It accepts a packed operand pair {A,B} per valid/ready handshake and produces one registered result per accepted pair. Modes cover eq/gt/lt flags, per-pair max/min, running max/min since clear, and a saturating A>B event counter. It sits between switch/operand capture logic and the display/result consumer.

---
 rtl/compare_pkg.sv | 19 +
 rtl/compare_core.sv | 31 +++
 rtl/compare_tracker.sv | 121 ++++++++++++
 3 files changed

// File: rtl/compare_pkg.sv
`default_nettype none
// compare_pkg: mode encodings and running-stats state type for compare_tracker.
// Rev 1.0
package compare_pkg;
  localparam logic [2:0] MODE_EQ   = 3'b000;
  localparam logic [2:0] MODE_GT   = 3'b001;
  localparam logic [2:0] MODE_LT   = 3'b010;
  localparam logic [2:0] MODE_MAX  = 3'b011;
  localparam logic [2:0] MODE_MIN  = 3'b100;
  localparam logic [2:0] MODE_RMAX = 3'b101;
  localparam logic [2:0] MODE_RMIN = 3'b110;
  localparam logic [2:0] MODE_CNT  = 3'b111;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_TRACK = 1'b1
  } stats_state_t;
endpackage
`default_nettype wire

// File: rtl/compare_core.sv
`default_nettype none
// compare_core: combinational compare of two operands, signed or unsigned.
// Rev 1.0
module compare_core #(
  parameter int WIDTH  = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] min_val
);
  generate
    if (SIGNED) begin : g_signed
      assign gt = $signed(a) > $signed(b);
      assign lt = $signed(a) < $signed(b);
    end else begin : g_unsigned
      assign gt = a > b;
      assign lt = a < b;
    end
  endgenerate

  assign eq = (a == b);
  // On a tie both operands are identical, so returning b is harmless.
  assign max_val = gt ? a : b;
  assign min_val = lt ? a : b;
endmodule
`default_nettype wire

// File: rtl/compare_tracker.sv
`default_nettype none
// compare_tracker: handshaked pair comparator with running max/min and A>B counter.
// Rev 1.0
module compare_tracker
  import compare_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] numi,
  input  logic [2:0]         sel,
  input  logic               clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] numo,
  output logic [2:0]         flags
);
  localparam int OW = 2 * WIDTH;

  logic [WIDTH-1:0] op_a, op_b;
  logic             accept;
  stats_state_t     state, state_nxt;
  logic [WIDTH-1:0] run_max, run_min;
  logic [OW-1:0]    count;

  logic             p_eq, p_gt, p_lt;
  logic [WIDTH-1:0] p_max, p_min, rmax_new, rmin_new;
  logic [WIDTH-1:0] max_next, min_next;
  logic [OW-1:0]    count_base, count_next;
  logic [OW-1:0]    result;
  logic             first_sample;

  logic [5:0]       cmp_unused;
  logic [WIDTH-1:0] rmax_unused_min, rmin_unused_max;

  assign op_a     = numi[OW-1:WIDTH];
  assign op_b     = numi[WIDTH-1:0];
  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  compare_core #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_pair (
    .a(op_a), .b(op_b), .eq(p_eq), .gt(p_gt), .lt(p_lt),
    .max_val(p_max), .min_val(p_min)
  );

  compare_core #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_run_max (
    .a(run_max), .b(p_max), .eq(cmp_unused[0]), .gt(cmp_unused[1]), .lt(cmp_unused[2]),
    .max_val(rmax_new), .min_val(rmax_unused_min)
  );

  compare_core #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_run_min (
    .a(run_min), .b(p_min), .eq(cmp_unused[3]), .gt(cmp_unused[4]), .lt(cmp_unused[5]),
    .max_val(rmin_unused_max), .min_val(rmin_new)
  );

  // A same-cycle clear makes the incoming pair the first sample of a fresh run.
  assign first_sample = clear | (state == ST_EMPTY);
  assign max_next     = first_sample ? p_max : rmax_new;
  assign min_next     = first_sample ? p_min : rmin_new;
  assign count_base   = clear ? '0 : count;
  assign count_next   = (p_gt && !(&count_base)) ? count_base + OW'(1) : count_base;

  always_comb begin
    state_nxt = state;
    if (clear)  state_nxt = ST_EMPTY;
    if (accept) state_nxt = ST_TRACK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_max <= '0;
      run_min <= '0;
      count   <= '0;
    end else if (accept) begin
      run_max <= max_next;
      run_min <= min_next;
      count   <= count_next;
    end else if (clear) begin
      count   <= '0;
    end
  end

  always_comb begin
    result = '0;
    case (sel)
      MODE_EQ:   result[0]         = p_eq;
      MODE_GT:   result[0]         = p_gt;
      MODE_LT:   result[0]         = p_lt;
      MODE_MAX:  result[WIDTH-1:0] = p_max;
      MODE_MIN:  result[WIDTH-1:0] = p_min;
      MODE_RMAX: result[WIDTH-1:0] = max_next;
      MODE_RMIN: result[WIDTH-1:0] = min_next;
      MODE_CNT:  result            = count_next;
      default:   result            = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      numo      <= '0;
      flags     <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      numo      <= result;
      flags     <= {p_lt, p_gt, p_eq};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
`default_nettype wire
